// File: rtl/motor_ctrl_target.sv
// Position-targeted step/dir motor channel: dir setup, then P-cycle step pulses until the target is reached.
// Optional trapezoidal ramp when MOTOR_CTRL_RAMP_EN is defined.
module motor_ctrl_target #(
    parameter int POS_W     = 20,
    parameter int DIV_W     = 13,
    parameter int DIR_SETUP = 16
`ifdef MOTOR_CTRL_RAMP_EN
    ,
    parameter int START_DIV = 4000,
    parameter int RAMP_DEC  = 100
`endif
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [POS_W-1:0] cmd_target,
    input  logic [DIV_W-1:0]        cmd_divider,
    input  logic                    enable,
    input  logic                    abort,
    input  logic                    pos_zero,
    output logic                    dir,
    output logic                    step,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] cur_position
);

    localparam int SET_W = $clog2(DIR_SETUP + 1);
    localparam int CNT_W = (DIV_W > SET_W) ? DIV_W : SET_W;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [POS_W:0]            r_rem, w_rem, w_diff;
    logic signed [POS_W-1:0]   r_pos, w_pos_base;
    logic [DIV_W-1:0]          r_per, w_per_step, w_cruise;
    logic                      r_abort, r_step, r_dir;
    logic                      w_abort_any, w_dir, w_enter_high;
`ifdef MOTOR_CTRL_RAMP_EN
    logic [DIV_W-1:0]          r_cruise;
    logic [POS_W:0]            r_acc, w_acc_nxt;
    logic [DIV_W:0]            w_up;
`endif

    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign step         = r_step;
    assign dir          = r_dir;
    assign cur_position = r_pos;

    // pos_zero takes effect before the distance to the new target is measured
    assign w_pos_base  = pos_zero ? '0 : r_pos;
    assign w_diff      = {cmd_target[POS_W-1], cmd_target} - {w_pos_base[POS_W-1], w_pos_base};
    assign w_rem       = w_diff[POS_W] ? (~w_diff + (POS_W+1)'(1)) : w_diff;
    assign w_dir       = !w_diff[POS_W] && (w_diff != '0);
    assign w_cruise    = (cmd_divider < DIV_W'(2)) ? DIV_W'(2) : cmd_divider;
    assign w_abort_any = r_abort | abort;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_state_nxt = (w_rem == '0) ? S_DONE : S_SETUP;
            S_SETUP: if (enable) begin
                         if (w_abort_any)       w_state_nxt = S_DONE;
                         else if (r_cnt == '0)  w_state_nxt = S_HIGH;
                     end
            S_HIGH:  if (enable && r_cnt == '0) w_state_nxt = S_LOW;
            S_LOW:   if (enable && r_cnt == '0)
                         w_state_nxt = (r_rem == '0 || w_abort_any) ? S_DONE : S_HIGH;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_high = (w_state_nxt == S_HIGH) && (r_state != S_HIGH);

    // Period for the step about to start; the ramp only adjusts it between steps
    always_comb begin
        w_per_step = r_per;
`ifdef MOTOR_CTRL_RAMP_EN
        w_acc_nxt = r_acc;
        w_up      = {1'b0, r_per} + (DIV_W+1)'(RAMP_DEC);
        if (r_state == S_LOW) begin
            if (r_rem <= r_acc) begin
                w_per_step = (w_up > (DIV_W+1)'(START_DIV)) ? DIV_W'(START_DIV) : w_up[DIV_W-1:0];
                w_acc_nxt  = r_acc - (POS_W+1)'(1);
            end else if (r_per > r_cruise) begin
                w_per_step = ((r_per - r_cruise) <= DIV_W'(RAMP_DEC)) ? r_cruise
                                                                       : r_per - DIV_W'(RAMP_DEC);
                w_acc_nxt  = r_acc + (POS_W+1)'(1);
            end
        end
`endif
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_pos   <= '0;
            r_per   <= '0;
            r_abort <= 1'b0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
`ifdef MOTOR_CTRL_RAMP_EN
            r_cruise <= '0;
            r_acc    <= '0;
`endif
        end else if (r_state == S_IDLE) begin
            if (pos_zero) r_pos <= '0;
            if (cmd_valid) begin
                r_rem   <= w_rem;
                r_abort <= 1'b0;
                r_cnt   <= CNT_W'(DIR_SETUP - 1);
                if (w_rem != '0) r_dir <= w_dir;
`ifdef MOTOR_CTRL_RAMP_EN
                r_cruise <= w_cruise;
                r_per    <= (w_cruise < DIV_W'(START_DIV)) ? DIV_W'(START_DIV) : w_cruise;
                r_acc    <= '0;
`else
                r_per    <= w_cruise;
`endif
            end
        end else if (enable) begin
            if (abort) r_abort <= 1'b1;
            if (w_enter_high) begin
                r_step <= 1'b1;
                r_pos  <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
                r_rem  <= r_rem - (POS_W+1)'(1);
                r_per  <= w_per_step;
                r_cnt  <= CNT_W'((w_per_step >> 1) - DIV_W'(1));
`ifdef MOTOR_CTRL_RAMP_EN
                r_acc  <= w_acc_nxt;
`endif
            end else if (r_state == S_HIGH && r_cnt == '0) begin
                r_step <= 1'b0;
                r_cnt  <= CNT_W'(r_per - (r_per >> 1) - DIV_W'(1));
            end else if (r_cnt != '0) begin
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/motor_ctrl_target.md
# motor_ctrl_target

Parametrised step/dir motor channel that executes position-targeted moves. A command carries a signed target position and a cruise step period. The block drives `dir`, waits a direction setup time, then emits step pulses until `cur_position` equals the target. An optional compile-time trapezoidal acceleration ramp is available. One instance sits per axis between the command sequencer and the driver pins.

## Interface
- `POS_W`, 20: width of signed positions
- `DIV_W`, 13: width of period values (clock cycles)
- `DIR_SETUP`, 16: cycles from `dir` update to the first step rising edge (≥1)
- `START_DIV`, 4000: ramp start/stop period (ramp build only)
- `RAMP_DEC`, 100: period change per step while ramping (ramp build only)

Ports:
- `CLK`  in  1  system clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_target`  in  POS_W  signed target position
- `cmd_divider`  in  DIV_W  cruise step period in cycles; values <2 treated as 2
- `enable`  in  1  low freezes all counters and holds `step`/`dir` levels
- `abort`  in  1  sync; end move after the current step's low phase
- `pos_zero`  in  1  sync; clears `cur_position` when in IDLE, ignored otherwise
- `dir`  out  1  1 = increasing position
- `step`  out  1  step pulse
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle pulse on return to IDLE
- `cur_position`  out  POS_W  signed position counter

## Operation
- Reset values: state IDLE, `step`=0, `dir`=0, `cur_position`=0, `done`=0, `busy`=0, `cmd_ready`=1.
- Accept on `cmd_valid && cmd_ready`.
  - Latch the period.
  - Compute `rem = |cmd_target - cur_position|` in POS_W+1 bits.
  - Set `dir = (cmd_target > cur_position)`.
  - If `rem`=0: go to DONE directly with no steps and no `dir` change.
- States:
  - IDLE
  - DIR_SETUP: count `DIR_SETUP` cycles.
  - STEP_HIGH: `step`=1 for P>>1 cycles.
  - STEP_LOW: `step`=0 for P-(P>>1) cycles.
  - DONE: one cycle, `done`=1, then IDLE.
- On entry to STEP_HIGH:
  - `cur_position` increments or decrements by 1, in the same edge as `step` rising.
  - `rem` decrements.
- End of STEP_LOW:
  - If `rem`=0 or an abort is pending: go to DONE.
  - Else: go to STEP_HIGH.
- `abort` is sampled in any non-IDLE state and latched. An abort during DIR_SETUP goes to DONE with no steps.
- `cur_position` wraps modulo 2^POS_W. There is no saturation.
- `enable`=0 stalls state, counters and abort latching; outputs hold. `reset` overrides everything asynchronously, including mid-pulse: `step` drops immediately.
- `pos_zero` and command acceptance in the same cycle: zero applies first, and `rem` is computed from 0.

## Timing
- Accept at edge N → `busy`=1, `cmd_ready`=0, `dir` valid from N+1.
- First `step` rise at N+1+DIR_SETUP.
- Consecutive rising edges are exactly P cycles apart. Here P is the period applied to that step.
- `done` is asserted in the cycle after the last STEP_LOW cycle. `cmd_ready` rises the cycle after `done`.
- Minimum command-to-command spacing is 2 cycles (accept → DONE → IDLE) for a zero-length move.

## Configuration
- `MOTOR_CTRL_RAMP_EN` defined:
  - On accept: P=`START_DIV`, `acc`=0.
  - The first step uses P unchanged.
  - At each subsequent STEP_HIGH entry, with `rem` counting steps left including this one:
    - If `rem` ≤ `acc`: P += `RAMP_DEC` (clamped to `START_DIV`), and `acc` -= 1.
    - Else if P > cruise: P -= `RAMP_DEC` (clamped to cruise), and `acc` += 1.
  - Cruise below `START_DIV` is required. Otherwise P stays constant at cruise.
- Undefined: P = cruise period for every step. `START_DIV`, `RAMP_DEC` and all ramp registers are absent.

## Test plan
- No ramp, DIR_SETUP=4, pos 0, target 3, divider 10 → rises at N+5, N+15, N+25, each high 5 cycles; `cur_position`=3; `done` at N+35; `dir`=1.
- No ramp, from 3, target −2, divider 7 → `dir`=0, 5 steps, high 3 / low 4 cycles, `cur_position`=−2.
- Ramp, START_DIV=40, RAMP_DEC=10, divider 10, 0→10 → step periods 40,30,20,10,10,10,10,20,30,40.
- `abort` pulsed during step 2 of a 100-step move → exactly 2 steps, `done` after step 2 low phase, `cur_position`=2; `enable` held low 20 cycles mid-pulse stretches that pulse by 20.
- Target equals position → `done` at N+1, no `step`; `pos_zero` while busy ignored, then honoured in IDLE (→0).
- `reset` asserted mid STEP_HIGH → `step`, `dir`, `cur_position` 0 immediately; `cmd_ready`=1 after release.
